// File: rtl/urv_irq_ctrl_pkg.sv
// Shared constants for the uRV interrupt controller: register offsets, gateway
// state encoding and the interrupt ID width, next to the core CSR/exception codes.
package urv_irq_ctrl_pkg;

  localparam int IRQ_ID_W = 5;

  localparam logic [3:0] REG_OFF_PENDING = 4'h0;
  localparam logic [3:0] REG_OFF_ENABLE  = 4'h4;
  localparam logic [3:0] REG_OFF_CLAIM   = 4'h8;
  localparam logic [3:0] REG_OFF_MODE    = 4'hC;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  // Core-side CSR addresses and the machine external interrupt cause code.
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [3:0]  EXC_MEXT_IRQ = 4'd11;

endpackage

// File: rtl/urv_irq_ctrl_if.sv
// Register-window bus between the core and the interrupt controller.
// Handshake: a one-cycle reg_we_i/reg_re_i strobe is answered by reg_ack_o exactly
// one cycle later; reg_rdata_o is valid only with ack; write wins if both strobes are high.
interface urv_irq_ctrl_if;
  logic [3:0]  reg_addr_i;
  logic        reg_we_i;
  logic        reg_re_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_ack_o;

  modport master (
    output reg_addr_i, reg_we_i, reg_re_i, reg_wdata_i,
    input  reg_rdata_o, reg_ack_o
  );

  modport slave (
    input  reg_addr_i, reg_we_i, reg_re_i, reg_wdata_i,
    output reg_rdata_o, reg_ack_o
  );
endinterface

// File: rtl/urv_irq_gateway.sv
// Per-source gateway: IDLE -> PENDING on request, -> CLAIMED on claim, -> IDLE on complete.
// With URV_IRQ_EDGE_DETECT_EN a source can be made rising-edge sensitive via mode.
module urv_irq_gateway
  import urv_irq_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      src,
`ifdef URV_IRQ_EDGE_DETECT_EN
  input  logic      mode,
`endif
  input  logic      claim,
  input  logic      complete,
  output logic      pending,
  output gw_state_e state
);

  gw_state_e state_nx;
  logic      req;

`ifdef URV_IRQ_EDGE_DETECT_EN
  logic src_q;
  logic edge_hold;
  logic rise;

  assign rise = src & ~src_q;
  assign req  = mode ? (rise | edge_hold) : src;

  // An edge arriving while busy is remembered once and replayed when IDLE is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= 1'b0;
      edge_hold <= 1'b0;
    end else begin
      src_q <= src;
      if (state == GW_IDLE) edge_hold <= 1'b0;
      else if (mode && rise) edge_hold <= 1'b1;
    end
  end
`else
  assign req = src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GW_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      GW_IDLE:    if (req)      state_nx = GW_PENDING;
      GW_PENDING: if (claim)    state_nx = GW_CLAIMED;
      GW_CLAIMED: if (complete) state_nx = GW_IDLE;
      default:                  state_nx = GW_IDLE;
    endcase
  end

  assign pending = (state == GW_PENDING);

endmodule

// File: rtl/urv_irq_ctrl.sv
// uRV interrupt controller: per-source gateways, ENABLE mask, claim/complete register
// window and registered irq_o. Optional edge-sensitive sources: URV_IRQ_EDGE_DETECT_EN.
module urv_irq_ctrl
  import urv_irq_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SOURCES-1:0]   src_i,
  output logic                     irq_o,
  urv_irq_ctrl_if.slave            bus,
  output logic [2*NUM_SOURCES-1:0] gw_state
);

  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] enable_q;
  logic [NUM_SOURCES-1:0] pend_en;
  logic [NUM_SOURCES-1:0] claim_vec;
  logic [NUM_SOURCES-1:0] complete_vec;
  logic [IRQ_ID_W-1:0]    claim_id;
  logic [IRQ_ID_W-1:0]    cmp_id;
  logic [3:0]             reg_off;
  logic [31:0]            rd_val;
  logic [31:0]            rdata_q;
  logic                   ack_q;
  logic                   irq_q;
  logic                   wr;
  logic                   rd;
  logic                   found;
  logic                   unused_bits;

`ifdef URV_IRQ_EDGE_DETECT_EN
  logic [NUM_SOURCES-1:0] mode_q;
`endif

  assign wr          = bus.reg_we_i;
  assign rd          = bus.reg_re_i & ~bus.reg_we_i;
  assign reg_off     = {bus.reg_addr_i[3:2], 2'b00};
  assign cmp_id      = bus.reg_wdata_i[IRQ_ID_W-1:0];
  assign pend_en     = pending & enable_q;
  assign unused_bits = ^{bus.reg_addr_i[1:0], bus.reg_wdata_i};

  // Claim selection works on pre-edge state, so a same-cycle new request cannot win.
  always_comb begin
    claim_id  = '0;
    claim_vec = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!found && pend_en[i]) begin
        found    = 1'b1;
        claim_id = IRQ_ID_W'(i + 1);
        if (rd && reg_off == REG_OFF_CLAIM) claim_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    complete_vec = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      complete_vec[i] = wr && (reg_off == REG_OFF_CLAIM) && (cmp_id == IRQ_ID_W'(i + 1));
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_gw
    gw_state_e st;
    urv_irq_gateway u_gw (
      .clk      (clk_i),
      .rst      (rst_i),
      .src      (src_i[g]),
`ifdef URV_IRQ_EDGE_DETECT_EN
      .mode     (mode_q[g]),
`endif
      .claim    (claim_vec[g]),
      .complete (complete_vec[g]),
      .pending  (pending[g]),
      .state    (st)
    );
    assign gw_state[2*g +: 2] = st;
  end

  always_comb begin
    rd_val = '0;
    case (reg_off)
      REG_OFF_PENDING: rd_val[NUM_SOURCES-1:0] = pending;
      REG_OFF_ENABLE:  rd_val[NUM_SOURCES-1:0] = enable_q;
      REG_OFF_CLAIM:   rd_val[IRQ_ID_W-1:0]    = claim_id;
`ifdef URV_IRQ_EDGE_DETECT_EN
      REG_OFF_MODE:    rd_val[NUM_SOURCES-1:0] = mode_q;
`endif
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q   <= wr | rd;
      rdata_q <= rd ? rd_val : 32'h0;
      irq_q   <= |pend_en;
      if (wr && reg_off == REG_OFF_ENABLE) enable_q <= bus.reg_wdata_i[NUM_SOURCES-1:0];
    end
  end

`ifdef URV_IRQ_EDGE_DETECT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mode_q <= '0;
    else if (wr && reg_off == REG_OFF_MODE) mode_q <= bus.reg_wdata_i[NUM_SOURCES-1:0];
  end
`endif

  assign irq_o           = irq_q;
  assign bus.reg_ack_o   = ack_q;
  assign bus.reg_rdata_o = rdata_q;

endmodule
